check_event_log: RTL and testbench
==================================

Name: check_event_log

Overview:
- Consumes the per-lane condition vectors that feed the `disp`-style `always @(posedge clk) if (!(a[i].b && c[i]))` checks.
- Detects failing lanes each cycle and timestamps them.
- Buffers failure records in a small FIFO for a downstream reader (trace port or testbench scoreboard) over a valid/ready handshake.
- Replaces simulation-only `$display` reporting with synthesizable capture.

Parameters:
- N_LANES, 4: number of checked lanes (index i). Range 1..32.
- DEPTH, 8: FIFO entries. Power of 2, at least 2.
- TS_W, 16: timestamp counter width.
- DROP_W, 8: dropped-record counter width.

Ports:
- clk  in  1  clock; all logic on posedge clk.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  check enable. When low, no failures are detected; timestamp still counts.
- dedup  in  1  1 = log only when the failure mask changes from the previous cycle's mask.
- flush  in  1  synchronous FIFO clear.
- lane_b  in  N_LANES  per-lane b term.
- lane_c  in  N_LANES  per-lane c term.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  reader accepts the head entry.
- out_mask  out  N_LANES  failing-lane mask of the head entry.
- out_ts  out  TS_W  timestamp of the head entry.
- count  out  $clog2(DEPTH)+1  current occupancy.
- dropped  out  DROP_W  saturating count of records lost to full or flush.

Behaviour:
- Reset values: out_valid=0, out_mask=0, out_ts=0, count=0, dropped=0. Pointers, timestamp and prev_mask are all 0.
- Failure mask:
  - fail[i] = en & ~(lane_b[i] & lane_c[i]).
  - The mask is the combinational vector of fail[i].
- Record generation (push request):
  - dedup=0: push when fail != 0.
  - dedup=1: push when fail != 0 and fail != prev_mask.
  - prev_mask <= fail every cycle, regardless of push.
- Timestamp: free-running TS_W counter, +1 per cycle, wraps 2^TS_W-1 -> 0. A record captures the pre-increment value of the cycle it is detected in.
- Latency: a failure in cycle k gives out_valid=1 at cycle k+1 if the FIFO was empty. Output is first-word-fall-through.
- Pop: out_valid & out_ready. The head advances at the next edge.
- FIFO:
  - Storage is DEPTH x (N_LANES+TS_W).
  - Pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - full = MSBs differ and low bits are equal.
  - empty = pointers equal.
- Simultaneous events:
  - Push and pop while not empty: both occur; count unchanged.
  - Push and pop while full: pop frees a slot, push accepted, count stays DEPTH.
  - Push while full without pop: record discarded; dropped += 1, saturating at 2^DROP_W-1.
  - Push and pop while empty: push only (no bypass). out_valid rises next cycle.
- Flush (priority over push and pop):
  - Pointers and count go to 0.
  - dropped += count, saturating. A push request in the same cycle also counts as dropped.
  - Timestamp and prev_mask are not affected.
- Handshake rule: out_mask and out_ts hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation: everything returns to reset values immediately (async assert). Deassertion is synchronous to clk externally. No record is produced in the first cycle after deassert unless a failure is present.

Decomposition:
- Package check_event_pkg:
  - typedef ev_rec_t struct packed {logic [TS_W-1:0] ts; logic [N_LANES-1:0] mask;}.
  - Localparam helpers PTR_W = $clog2(DEPTH)+1.
  - Default constants for N_LANES and TS_W.
- One sub-module: check_event_fifo. A generic synchronous FWFT FIFO with push/pop/flush/full/empty/count.
- The top holds detection, dedup, timestamp and drop counter.

Test Plan:
1. Reset, then en=1, lane_b=lane_c=4'hF for 10 cycles -> out_valid stays 0, count=0, dropped=0.
2. At ts=5, drive lane_b=4'b1101, lane_c=4'hF for one cycle, out_ready=0 -> next cycle out_valid=1, out_mask=4'b0010, out_ts=5; the entry holds until out_ready=1, then out_valid=0.
3. dedup=1, hold failing mask 4'b0001 for 5 cycles, then 4'b0011 for 1 cycle -> exactly 2 entries (masks 0001, 0011). With dedup=0, the same stimulus yields 6 entries.
4. DEPTH=8, out_ready=0, fail for 11 consecutive cycles -> count=8, dropped=3, entries hold the first 8 timestamps. Then one cycle with push + pop while full -> count=8, dropped=3.
5. With count=5, assert flush together with a failing lane -> next cycle count=0, out_valid=0, dropped=6.
6. TS_W=4: a failure at ts=15 and another at the next cycle -> out_ts sequence 15, 0. Assert rst mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/check_event_pkg.sv
// Shared types and constants for the check event logger.
//
// Contents:
//   N_LANES_DEF / TS_W_DEF / DEPTH_DEF : default sizes for the top and the FIFO.
//   ptr_w()                            : width of a FIFO pointer.
//                                        One bit wider than the address,
//                                        so full and empty can be told apart.
//   PTR_W                              : pointer width at the default depth.
//   ev_rec_t                           : one failure record at the default sizes.
package check_event_pkg;

    localparam int N_LANES_DEF = 4;
    localparam int TS_W_DEF    = 16;
    localparam int DEPTH_DEF   = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W = ptr_w(DEPTH_DEF);

    typedef struct packed {
        logic [TS_W_DEF-1:0]    ts;
        logic [N_LANES_DEF-1:0] mask;
    } ev_rec_t;

endpackage

// File: rtl/check_event_log_if.sv
// Record output stream of check_event_log.
// This is a first-word-fall-through valid/ready stream.
//
// Signals:
//   out_valid : a record is presented (the FIFO is not empty).
//   out_ready : the reader accepts the presented record.
//   out_mask  : failing-lane mask of the presented record.
//   out_ts    : timestamp of the presented record.
// The master modport is the logger. The slave modport is the reader.
interface check_event_log_if #(
    parameter int N_LANES = 4,
    parameter int TS_W    = 16
) ();
    logic               out_valid;
    logic               out_ready;
    logic [N_LANES-1:0] out_mask;
    logic [TS_W-1:0]    out_ts;

    modport master (output out_valid, out_mask, out_ts, input out_ready);
    modport slave  (input out_valid, out_mask, out_ts, output out_ready);
endinterface

// File: rtl/check_event_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset.
//   push_i/wdata_i: write request and data.
//                   Ignored when full, unless a pop frees a slot in the same cycle.
//   pop_i         : consume the head entry. Ignored when empty.
//   flush_i       : synchronous clear. Takes priority over push and pop.
//   rdata_o       : head entry. Reads as 0 while empty.
//   full_o, empty_o, count_o : status flags and occupancy.
module check_event_fifo
    import check_event_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic                      flush_i,
    input  logic [WIDTH-1:0]          wdata_i,
    output logic [WIDTH-1:0]          rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [ptr_w(DEPTH)-1:0]   count_o
);
    localparam int PB = ptr_w(DEPTH);
    localparam int AW = PB - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PB-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PB-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // The top pointer bit is a wrap flag.
    // When the address bits match, equal wrap flags mean empty and differing flags mean full.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PB'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PB'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    // Gate the head so a stale entry never shows while the FIFO is empty.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/check_event_log.sv
// Synthesizable capture of per-lane check failures.
//
// Each cycle, lane i fails when the check is enabled and !(lane_b[i] && lane_c[i]).
// A cycle with any failing lane produces a record {timestamp, mask}.
// With dedup set, a record is produced only when the mask differs from the previous cycle's mask.
// Records are queued in a FWFT FIFO and read out over out_if.
// Records lost because the FIFO is full or flushed are counted in a saturating counter.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset.
//   en            : check enable. The timestamp runs regardless of en.
//   dedup         : log only when the failure mask changes.
//   flush         : synchronous FIFO clear. Flushed records count as dropped.
//   lane_b/lane_c : per-lane condition terms.
//   out_if        : record stream (master side).
//   count         : FIFO occupancy.
//   dropped       : saturating count of lost records.
module check_event_log
    import check_event_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TS_W    = TS_W_DEF,
    parameter int DROP_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     dedup,
    input  logic                     flush,
    input  logic [N_LANES-1:0]       lane_b,
    input  logic [N_LANES-1:0]       lane_c,
    check_event_log_if.master        out_if,
    output logic [ptr_w(DEPTH)-1:0]  count,
    output logic [DROP_W-1:0]        dropped
);
    localparam int PB    = ptr_w(DEPTH);
    // Wide enough to hold dropped + count + 1 without overflowing before saturation.
    localparam int SUM_W = ((DROP_W > PB) ? DROP_W : PB) + 1;
    localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [N_LANES-1:0] mask;
    } rec_t;

    logic [N_LANES-1:0] fail;
    logic [N_LANES-1:0] prev_mask_q;
    logic [TS_W-1:0]    ts_q;
    logic [DROP_W-1:0]  dropped_q, dropped_d;
    logic [SUM_W-1:0]   drop_inc, drop_sum;
    logic               push_req, pop;
    logic               fifo_full, fifo_empty;
    rec_t               wr_rec, head;

    assign fail     = {N_LANES{en}} & ~(lane_b & lane_c);
    assign push_req = (|fail) && (!dedup || (fail != prev_mask_q));
    assign pop      = ~fifo_empty & out_if.out_ready;
    assign wr_rec   = '{ts: ts_q, mask: fail};

    check_event_fifo #(
        .WIDTH (N_LANES + TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wr_rec),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // A flush discards every queued record plus any record arriving in the same cycle.
    // Otherwise a record is lost only when it meets a full FIFO with no pop to free a slot.
    always_comb begin
        drop_inc = '0;
        if (flush) begin
            drop_inc = SUM_W'(count) + SUM_W'(push_req);
        end else if (push_req && fifo_full && !pop) begin
            drop_inc = SUM_W'(1);
        end
        drop_sum  = SUM_W'(dropped_q) + drop_inc;
        dropped_d = (drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q        <= '0;
            prev_mask_q <= '0;
            dropped_q   <= '0;
        end else begin
            ts_q        <= ts_q + TS_W'(1);
            prev_mask_q <= fail;
            dropped_q   <= dropped_d;
        end
    end

    assign out_if.out_valid = ~fifo_empty;
    assign out_if.out_mask  = head.mask;
    assign out_if.out_ts    = head.ts;
    assign dropped          = dropped_q;

endmodule

// File: tb/tb_check_event_log.sv
module tb_check_event_log;
    import check_event_pkg::*;

    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst, en, dedup, flush, ready;
    logic [3:0]       lane_b, lane_c;
    logic [PTR_W-1:0] count_a, count_b;
    logic [7:0]       dropped_a, dropped_b;

    check_event_log_if #(.N_LANES(4), .TS_W(16)) if_a ();
    check_event_log_if #(.N_LANES(4), .TS_W(4))  if_b ();
    assign if_a.out_ready = ready;
    assign if_b.out_ready = ready;

    check_event_log #(.N_LANES(4), .DEPTH(DEPTH), .TS_W(16), .DROP_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .dedup(dedup), .flush(flush),
        .lane_b(lane_b), .lane_c(lane_c), .out_if(if_a),
        .count(count_a), .dropped(dropped_a)
    );

    check_event_log #(.N_LANES(4), .DEPTH(DEPTH), .TS_W(4), .DROP_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .dedup(dedup), .flush(flush),
        .lane_b(lane_b), .lane_c(lane_c), .out_if(if_b),
        .count(count_b), .dropped(dropped_b)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    ev_rec_t    exp_q[$];
    int         m_ts;
    logic [3:0] m_prev;
    int         m_dropped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ts      = 0;
        m_prev    = '0;
        m_dropped = 0;
    endtask

    // Compare DUT A against the scoreboard head and the model counters.
    task automatic check_model();
        check("valid", if_a.out_valid, exp_q.size() != 0);
        check("count", count_a, exp_q.size());
        check("dropped", dropped_a, m_dropped);
        if (exp_q.size() != 0) begin
            check("head_mask", if_a.out_mask, exp_q[0].mask);
            check("head_ts", if_a.out_ts, exp_q[0].ts);
        end
    endtask

    // Drive one clock of stimulus and update the scoreboard.
    // Call this at posedge+1; it returns at the next posedge+1.
    task automatic cycle(input logic [3:0] b, input logic [3:0] c,
                         input logic rdy, input logic fl);
        logic [3:0] f;
        logic       push, pop;
        ev_rec_t    r, dummy;
        lane_b = b;
        lane_c = c;
        ready  = rdy;
        flush  = fl;
        f      = en ? ~(b & c) : 4'b0;
        push   = (f != 4'b0) && (!dedup || f != m_prev);
        pop    = (exp_q.size() != 0) && rdy;
        r.ts   = m_ts[15:0];
        r.mask = f;
        if (fl) begin
            m_dropped += exp_q.size() + (push ? 1 : 0);
            exp_q.delete();
        end else begin
            if (pop) dummy = exp_q.pop_front();
            if (push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(r);
                else m_dropped++;
            end
        end
        if (m_dropped > 255) m_dropped = 255;
        m_prev = f;
        m_ts   = (m_ts + 1) % 65536;
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Assert reset between edges and check that both DUTs clear without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_valid_a", if_a.out_valid, 1'b0);
        check("rst_mask_a", if_a.out_mask, 4'h0);
        check("rst_ts_a", if_a.out_ts, 16'h0);
        check("rst_count_a", count_a, 0);
        check("rst_dropped_a", dropped_a, 8'h0);
        check("rst_valid_b", if_b.out_valid, 1'b0);
        check("rst_ts_b", if_b.out_ts, 4'h0);
        check("rst_count_b", count_b, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        en = 1'b1; dedup = 1'b0; flush = 1'b0; ready = 1'b0;
        lane_b = 4'hF; lane_c = 4'hF;
        #1;
        do_reset();

        // 1: all lanes pass -> nothing logged.
        repeat (10) cycle(4'hF, 4'hF, 1'b0, 1'b0);
        check("t1_count", count_a, 0);
        check("t1_valid", if_a.out_valid, 1'b0);
        // Check disabled: failing lanes are ignored.
        en = 1'b0;
        cycle(4'h0, 4'h0, 1'b0, 1'b0);
        check("en0_valid", if_a.out_valid, 1'b0);
        en = 1'b1;

        // 2: single failure at ts=5, held until accepted.
        do_reset();
        repeat (5) cycle(4'hF, 4'hF, 1'b0, 1'b0);
        cycle(4'b1101, 4'hF, 1'b0, 1'b0);
        check("t2_valid", if_a.out_valid, 1'b1);
        check("t2_mask", if_a.out_mask, 4'b0010);
        check("t2_ts", if_a.out_ts, 16'd5);
        repeat (3) cycle(4'hF, 4'hF, 1'b0, 1'b0);
        check("t2_hold_mask", if_a.out_mask, 4'b0010);
        check("t2_hold_ts", if_a.out_ts, 16'd5);
        cycle(4'hF, 4'hF, 1'b1, 1'b0);
        check("t2_popped", if_a.out_valid, 1'b0);

        // 3: dedup on, then off, with the same stimulus.
        dedup = 1'b1;
        repeat (5) cycle(4'b1110, 4'hF, 1'b0, 1'b0);
        cycle(4'b1100, 4'hF, 1'b0, 1'b0);
        cycle(4'hF, 4'hF, 1'b0, 1'b0);
        check("t3_dedup_count", count_a, 2);
        check("t3_first_mask", if_a.out_mask, 4'b0001);
        cycle(4'hF, 4'hF, 1'b1, 1'b0);
        check("t3_second_mask", if_a.out_mask, 4'b0011);
        cycle(4'hF, 4'hF, 1'b1, 1'b0);
        dedup = 1'b0;
        repeat (5) cycle(4'b1110, 4'hF, 1'b0, 1'b0);
        cycle(4'b1100, 4'hF, 1'b0, 1'b0);
        cycle(4'hF, 4'hF, 1'b0, 1'b0);
        check("t3_nodedup_count", count_a, 6);
        repeat (6) cycle(4'hF, 4'hF, 1'b1, 1'b0);
        check("t3_drained", count_a, 0);

        // 4: overflow, then push and pop while full.
        repeat (11) cycle(4'b1110, 4'hF, 1'b0, 1'b0);
        check("t4_count", count_a, 8);
        check("t4_dropped", dropped_a, 8'd3);
        cycle(4'b1110, 4'hF, 1'b1, 1'b0);
        check("t4_pp_count", count_a, 8);
        check("t4_pp_dropped", dropped_a, 8'd3);

        // 5: flush with five queued and a failure in the same cycle.
        do_reset();
        repeat (5) cycle(4'b1110, 4'hF, 1'b0, 1'b0);
        check("t5_count", count_a, 5);
        cycle(4'b1110, 4'hF, 1'b0, 1'b1);
        check("t5_flush_count", count_a, 0);
        check("t5_flush_valid", if_a.out_valid, 1'b0);
        check("t5_flush_dropped", dropped_a, 8'd6);
        cycle(4'b1110, 4'hF, 1'b0, 1'b0);

        // 6: timestamp wrap on the TS_W=4 instance, then reset mid-stream.
        do_reset();
        repeat (15) cycle(4'hF, 4'hF, 1'b0, 1'b0);
        cycle(4'b1101, 4'hF, 1'b0, 1'b0);
        cycle(4'b1011, 4'hF, 1'b0, 1'b0);
        cycle(4'hF, 4'hF, 1'b0, 1'b0);
        check("t6_count_b", count_b, 2);
        check("t6_ts_first", if_b.out_ts, 4'd15);
        check("t6_mask_first", if_b.out_mask, 4'b0010);
        cycle(4'hF, 4'hF, 1'b1, 1'b0);
        check("t6_ts_wrapped", if_b.out_ts, 4'd0);
        check("t6_mask_second", if_b.out_mask, 4'b0100);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
